// File: rtl/lod_rr_arbiter_if.sv
// Request/response bundle for lod_rr_arbiter: NUM_REQ valid/ready requesters
// in, one tagged leading-one-position result out.
interface lod_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 12
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int POS_W = $clog2(DATA_W + 1);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [POS_W-1:0]          rsp_pos;
    logic                      rsp_zero;

    // Requesters and the downstream normalisation stage.
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_pos, rsp_zero
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_pos, rsp_zero
    );
endinterface

// File: rtl/lod_rr_arbiter.sv
// Round-robin arbiter sharing one registered leading-one-position encoder.
// Optional macro LOD_STATS_EN adds saturating accept / zero-result counters.
module lod_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 12,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int POS_W   = $clog2(DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    lod_rr_arbiter_if.slave  bus,
`ifdef LOD_STATS_EN
    output logic [15:0]      stat_cnt,
    output logic [15:0]      stat_zero_cnt,
`endif
    output logic [1:0]       dbg_state,
    output logic [ID_W-1:0]  dbg_rr_ptr
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. valid never waits on ready, and once raised it stays high with
    // stable payload until that transfer; ready may depend on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic [NUM_REQ-1:0] ready_c;
    logic [DATA_W-1:0]  cap_data;
    logic [ID_W-1:0]    cap_id;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [POS_W-1:0]   rsp_pos_q;
    logic               rsp_zero_q;
    logic               req_hs;
    logic               rsp_acc;

    function automatic logic [POS_W-1:0] lop(input logic [DATA_W-1:0] w);
        lop = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (w[i]) lop = POS_W'(i + 1);
        end
    endfunction

    // Search starts at rr_ptr so the last served requester is checked last.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ready_c = '0;
        if (state == IDLE && found) ready_c[grant_id] = 1'b1;
    end

    assign req_hs  = (state == IDLE) && found;
    assign rsp_acc = (state == RESP) && bus.rsp_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_hs) state_nx = ENC;
            ENC:     state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cap_data    <= '0;
            cap_id      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_pos_q   <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state       <= state_nx;
            rsp_valid_q <= (state_nx == RESP);
            if (req_hs) begin
                cap_data <= bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
                cap_id   <= grant_id;
            end
            if (state == ENC) begin
                rsp_id_q   <= cap_id;
                rsp_pos_q  <= lop(cap_data);
                rsp_zero_q <= ~|cap_data;
            end
            if (rsp_acc) rr_ptr <= ID_W'((int'(rsp_id_q) + 1) % NUM_REQ);
        end
    end

`ifdef LOD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cnt      <= '0;
            stat_zero_cnt <= '0;
        end else if (rsp_acc) begin
            if (stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
            if (rsp_zero_q && stat_zero_cnt != 16'hFFFF)
                stat_zero_cnt <= stat_zero_cnt + 16'd1;
        end
    end
`endif

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_pos   = rsp_pos_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign dbg_state     = state;
    assign dbg_rr_ptr    = rr_ptr;
endmodule

// File: tb/tb_lod_rr_arbiter.sv
// Bench for lod_rr_arbiter: directed vectors, a cycle-level behavioural model
// compared on every negative edge, and literal checks on the service log.
module tb_lod_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(W + 1);

    typedef struct {
        int id;
        int pos;
        int zero;
        int hs;
        int acc;
    } log_t;

    logic clk;
    logic rst_n;
    logic [1:0]    dbg_state;
    logic [IW-1:0] dbg_rr_ptr;
`ifdef LOD_STATS_EN
    logic [15:0] stat_cnt;
    logic [15:0] stat_zero_cnt;
`endif

    lod_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

    lod_rr_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
`ifdef LOD_STATS_EN
        .stat_cnt      (stat_cnt),
        .stat_zero_cnt (stat_zero_cnt),
`endif
        .dbg_state     (dbg_state),
        .dbg_rr_ptr    (dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [IW+PW:0] exp_q[$];   // {id, pos, zero} of the captured request
    int   hs_q[$];
    log_t svc_log[$];
    int   m_phase = 0;          // 0 waiting for a request, 1 encoding, 2 offering
    int   m_rr = 0;
    int   m_id = 0, m_pos = 0, m_zero = 0;
    int   m_stat = 0, m_zstat = 0;

    function automatic int msb_pos(input logic [W-1:0] w);
        int p;
        p = 0;
        while ((w >> p) != 0) p++;
        return p;
    endfunction

    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        logic [W-1:0] w;
        int g;
        if (!rst_n) begin
            m_phase = 0; m_rr = 0; m_id = 0; m_pos = 0; m_zero = 0;
            m_stat = 0; m_zstat = 0;
            exp_q.delete(); hs_q.delete();
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_pos", bus.rsp_pos, 0);
            chk("rst_rsp_zero", bus.rsp_zero, 0);
            chk("rst_rr_ptr", dbg_rr_ptr, 0);
        end else begin
            er = '0;
            g  = -1;
            if (m_phase == 0)
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) er[g] = 1'b1;
            chk("req_ready", bus.req_ready, er);
            chk("rsp_valid", bus.rsp_valid, (m_phase == 2));
            chk("rsp_id", bus.rsp_id, m_id);
            chk("rsp_pos", bus.rsp_pos, m_pos);
            chk("rsp_zero", bus.rsp_zero, m_zero);
            chk("rr_ptr", dbg_rr_ptr, m_rr);
`ifdef LOD_STATS_EN
            chk("stat_cnt", stat_cnt, m_stat);
            chk("stat_zero_cnt", stat_zero_cnt, m_zstat);
`endif
            case (m_phase)
                0: if (g >= 0) begin
                    w = bus.req_data[g*W +: W];
                    exp_q.push_back({IW'(g), PW'(msb_pos(w)), (w == 0)});
                    hs_q.push_back(cyc + 1);
                    m_phase = 1;
                end
                1: begin
                    m_id   = int'(exp_q[0][IW+PW:PW+1]);
                    m_pos  = int'(exp_q[0][PW:1]);
                    m_zero = int'(exp_q[0][0]);
                    m_phase = 2;
                end
                default: if (bus.rsp_ready) begin
                    svc_log.push_back('{id: int'(bus.rsp_id), pos: int'(bus.rsp_pos),
                                        zero: int'(bus.rsp_zero), hs: hs_q[0], acc: cyc + 1});
                    void'(exp_q.pop_front());
                    void'(hs_q.pop_front());
                    m_rr = (m_id + 1) % N;
                    if (m_stat < 16'hFFFF) m_stat++;
                    if (m_zero != 0 && m_zstat < 16'hFFFF) m_zstat++;
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] w);
        bus.req_data[i*W +: W] = w;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        svc_log.delete();
    endtask

    // Raise one requester and hold it until its transfer, then drop it.
    task automatic send(input int i, input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        set_data(i, w);
        bus.req_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = bus.req_valid[i] && bus.req_ready[i];
            tick();
        end
        bus.req_valid[i] = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 200 && svc_log.size() < n; k++) tick();
        if (svc_log.size() < n) chk("wait_log_timeout", svc_log.size(), n);
    endtask

    task automatic chk_log(input string nm, input int i, input int id, input int pos, input int zero);
        if (i < svc_log.size()) begin
            chk({nm, "_id"}, svc_log[i].id, id);
            chk({nm, "_pos"}, svc_log[i].pos, pos);
            chk({nm, "_zero"}, svc_log[i].zero, zero);
        end else begin
            chk({nm, "_missing"}, svc_log.size(), i + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;

        // 1: single request, MSB at bit 7
        apply_reset();
        bus.rsp_ready = 1'b1;
        send(0, 12'h0A0);
        wait_log(1);
        chk_log("t1", 0, 0, 8, 0);
        if (svc_log.size() > 0) chk("t1_latency", svc_log[0].acc - svc_log[0].hs, 2);

        // 2: all four valid continuously
        apply_reset();
        for (int i = 0; i < N; i++) set_data(i, 12'h001 << (3 * i));
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        wait_log(5);
        bus.req_valid = '0;
        chk_log("t2_0", 0, 0, 1, 0);
        chk_log("t2_1", 1, 1, 4, 0);
        chk_log("t2_2", 2, 2, 7, 0);
        chk_log("t2_3", 3, 3, 10, 0);
        chk_log("t2_4", 4, 0, 1, 0);
        for (int k = 1; k < 5 && k < svc_log.size(); k++)
            chk("t2_spacing", svc_log[k].acc - svc_log[k-1].acc, 3);

        // 3: all-zero word
        apply_reset();
        bus.rsp_ready = 1'b1;
        send(2, 12'h000);
        wait_log(1);
        chk_log("t3", 0, 2, 0, 1);
`ifdef LOD_STATS_EN
        chk("t3_stat_cnt", stat_cnt, 1);
        chk("t3_stat_zero_cnt", stat_zero_cnt, 1);
`endif

        // 4: back-pressure for 5 cycles in RESP, others waiting
        apply_reset();
        bus.rsp_ready = 1'b0;
        send(1, 12'h800);
        set_data(2, 12'h00F);
        set_data(3, 12'h100);
        bus.req_valid = 4'b1100;
        for (int k = 0; k < 10 && !bus.rsp_valid; k++) tick();
        repeat (5) tick();
        bus.rsp_ready = 1'b1;
        wait_log(2);
        bus.req_valid = '0;
        chk_log("t4_0", 0, 1, 12, 0);
        chk_log("t4_1", 1, 2, 4, 0);
        if (svc_log.size() > 0) chk("t4_hold", svc_log[0].acc - svc_log[0].hs, 7);

        // 5: reset pulse while a result is pending
        apply_reset();
        bus.rsp_ready = 1'b1;
        send(1, 12'h004);
        wait_log(1);
        chk("t5_rr_before", dbg_rr_ptr, 2);
        bus.rsp_ready = 1'b0;
        send(3, 12'h7FF);
        for (int k = 0; k < 10 && !bus.rsp_valid; k++) tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rsp_valid_async", bus.rsp_valid, 0);
        chk("t5_rr_async", dbg_rr_ptr, 0);
        tick();
        rst_n = 1'b1;
        svc_log.delete();
        set_data(0, 12'h020);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1001;
        wait_log(1);
        bus.req_valid = '0;
        chk_log("t5", 0, 0, 6, 0);

        // 6: short valid pulse during ENC is ignored
        apply_reset();
        bus.rsp_ready = 1'b1;
        send(1, 12'h010);
        set_data(3, 12'h3FF);
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = '0;
        wait_log(1);
        set_data(0, 12'h001);
        set_data(2, 12'h400);
        bus.req_valid = 4'b0101;
        wait_log(2);
        bus.req_valid = '0;
        repeat (4) tick();
        chk_log("t6_0", 0, 1, 5, 0);
        chk_log("t6_1", 1, 2, 11, 0);
        chk("t6_count", svc_log.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
